// File: rtl/next_pc_bp.sv
// Next-PC unit for the pipelined MIPS32 core: fetch PC register, 2-bit BHT,
// decode-stage jump/branch prediction and execute-stage mispredict recovery.
module next_pc_bp #(
  parameter int PC_W     = 30,
  parameter int BHT_IDX  = 4,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  output logic [PC_W-1:0]   o_PC,
  input  logic              i_d_valid,
  input  logic [PC_W-1:0]   i_d_PCp1,
  input  logic [25:0]       i_d_Imm,
  input  logic              i_d_J,
  input  logic              i_d_br,
  output logic              o_d_pred_taken,
  input  logic              i_e_valid,
  input  logic [PC_W-1:0]   i_e_PCp1,
  input  logic [15:0]       i_e_Imm,
  input  logic              i_e_beq,
  input  logic              i_e_bne,
  input  logic              i_e_Jr,
  input  logic              i_e_zero,
  input  logic              i_e_pred_taken,
  input  logic [31:0]       i_e_adr_JR,
  output logic              o_flush_fd,
  output logic              o_flush_de,
  output logic [CNT_W-1:0]  o_mispredicts
);

  localparam int BHT_N = 1 << BHT_IDX;

  function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [PC_W-1:0]        r_pc;
  logic [1:0]             r_bht [BHT_N];
  logic [CNT_W-1:0]       r_mis;

  logic signed [PC_W-1:0] w_d_off;
  logic signed [PC_W-1:0] w_e_off;
  logic [PC_W-1:0]        w_d_br_tgt;
  logic [PC_W-1:0]        w_e_br_tgt;
  logic [PC_W-1:0]        w_j_tgt;
  logic [PC_W+1:0]        w_jr_byte;
  logic [PC_W-1:0]        w_jr_tgt;
  logic                   w_unused_jr;
  logic [BHT_IDX-1:0]     w_d_idx;
  logic [BHT_IDX-1:0]     w_e_idx;
  logic                   w_d_pred;
  logic                   w_e_taken;
  logic                   w_e_br;
  logic                   w_e_jr;
  logic                   w_br_mis;
  logic                   w_e_redir;
  logic [PC_W-1:0]        w_e_tgt;
  logic                   w_d_redir;
  logic [PC_W-1:0]        w_d_tgt;

  // Target arithmetic wraps modulo 2^PC_W.
  assign w_d_off    = {{(PC_W-16){i_d_Imm[15]}}, i_d_Imm[15:0]};
  assign w_e_off    = {{(PC_W-16){i_e_Imm[15]}}, i_e_Imm};
  assign w_d_br_tgt = i_d_PCp1 + $unsigned(w_d_off);
  assign w_e_br_tgt = i_e_PCp1 + $unsigned(w_e_off);

  generate
    if (PC_W > 26) begin : g_jhi
      assign w_j_tgt = {i_d_PCp1[PC_W-1:26], i_d_Imm};
    end else begin : g_jlo
      assign w_j_tgt = i_d_Imm[PC_W-1:0];
    end
  endgenerate

  // JR register holds a byte address; the low two bits are dropped.
  assign w_jr_byte   = (PC_W+2)'(i_e_adr_JR);
  assign w_jr_tgt    = w_jr_byte[PC_W+1:2];
  assign w_unused_jr = ^w_jr_byte[1:0];

  assign w_d_idx  = i_d_PCp1[BHT_IDX-1:0];
  assign w_e_idx  = i_e_PCp1[BHT_IDX-1:0];
  assign w_d_pred = i_d_valid & i_d_br & r_bht[w_d_idx][1];

  assign w_e_taken = (i_e_beq & i_e_zero) | (i_e_bne & ~i_e_zero);
  assign w_e_br    = i_e_valid & (i_e_beq | i_e_bne);
  assign w_e_jr    = i_e_valid & i_e_Jr;
  assign w_br_mis  = w_e_br & (w_e_taken != i_e_pred_taken);
  assign w_e_redir = w_br_mis | w_e_jr;
  assign w_e_tgt   = i_e_Jr ? w_jr_tgt : (w_e_taken ? w_e_br_tgt : i_e_PCp1);

  assign w_d_redir = ~i_stall & i_d_valid & (i_d_J | w_d_pred);
  assign w_d_tgt   = i_d_J ? w_j_tgt : w_d_br_tgt;

  // Execute redirect outranks decode redirect and stall.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          r_pc <= PC_W'(RESET_PC);
    else if (w_e_redir) r_pc <= w_e_tgt;
    else if (w_d_redir) r_pc <= w_d_tgt;
    else if (!i_stall)  r_pc <= r_pc + PC_W'(1);
  end

  // Training ignores stall; a same-cycle decode read sees the pre-update value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < BHT_N; k++) r_bht[k] <= 2'b01;
    end else if (w_e_br) begin
      r_bht[w_e_idx] <= sat2(r_bht[w_e_idx], w_e_taken);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_mis <= '0;
    else if (w_br_mis) r_mis <= sat_inc(r_mis);
  end

  assign o_PC           = r_pc;
  assign o_d_pred_taken = w_d_pred;
  assign o_flush_fd     = w_e_redir | w_d_redir;
  assign o_flush_de     = w_e_redir;
  assign o_mispredicts  = r_mis;

endmodule

// File: tb/tb_next_pc_bp.sv
// Scoreboard bench for next_pc_bp: stimulus queues expected outputs, monitor
// compares them on the falling clock edge.
module tb_next_pc_bp;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [29:0] pc;
  logic        d_valid, d_J, d_br, d_pred;
  logic [29:0] d_PCp1;
  logic [25:0] d_Imm;
  logic        e_valid, e_beq, e_bne, e_Jr, e_zero, e_pred;
  logic [29:0] e_PCp1;
  logic [15:0] e_Imm;
  logic [31:0] e_adr_JR;
  logic        fl_fd, fl_de;
  logic [15:0] mis;

  next_pc_bp dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .o_PC(pc),
    .i_d_valid(d_valid), .i_d_PCp1(d_PCp1), .i_d_Imm(d_Imm), .i_d_J(d_J),
    .i_d_br(d_br), .o_d_pred_taken(d_pred),
    .i_e_valid(e_valid), .i_e_PCp1(e_PCp1), .i_e_Imm(e_Imm), .i_e_beq(e_beq),
    .i_e_bne(e_bne), .i_e_Jr(e_Jr), .i_e_zero(e_zero),
    .i_e_pred_taken(e_pred), .i_e_adr_JR(e_adr_JR),
    .o_flush_fd(fl_fd), .o_flush_de(fl_de), .o_mispredicts(mis)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [29:0] pc;
    bit          fd, de, pd;
    logic [15:0] mis;
    bit [3:0]    chk;   // {pc, flushes, prediction, mispredicts}
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Monitor
  initial begin
    exp_t it;
    bit   bad;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it  = q.pop_front();
        n_vec++;
        bad = 1'b0;
        if (it.chk[3] && pc !== it.pc) bad = 1'b1;
        if (it.chk[2] && (fl_fd !== it.fd || fl_de !== it.de)) bad = 1'b1;
        if (it.chk[1] && d_pred !== it.pd) bad = 1'b1;
        if (it.chk[0] && mis !== it.mis) bad = 1'b1;
        if (bad) begin
          n_err++;
          $display("FAIL %s: got pc=%h fd=%b de=%b pred=%b mis=%0d, want pc=%h fd=%b de=%b pred=%b mis=%0d (chk=%b)",
                   it.nm, pc, fl_fd, fl_de, d_pred, mis,
                   it.pc, it.fd, it.de, it.pd, it.mis, it.chk);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic expect_now(input string nm, input logic [29:0] p, input bit fd,
                            input bit de, input bit pd, input logic [15:0] m,
                            input bit [3:0] chk);
    exp_t it;
    it.nm = nm; it.pc = p; it.fd = fd; it.de = de; it.pd = pd; it.mis = m; it.chk = chk;
    q.push_back(it);
  endtask

  task automatic cyc(input string nm, input logic [29:0] p, input bit fd,
                     input bit de, input bit pd, input logic [15:0] m,
                     input bit [3:0] chk);
    expect_now(nm, p, fd, de, pd, m, chk);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    d_valid = 0; d_J = 0; d_br = 0; d_PCp1 = '0; d_Imm = '0;
    e_valid = 0; e_beq = 0; e_bne = 0; e_Jr = 0; e_zero = 0; e_pred = 0;
    e_PCp1 = '0; e_Imm = '0; e_adr_JR = '0;
  endtask

  // BNE at index 5 resolved with a matching prediction, so no redirect.
  task automatic exe_bne(input bit taken);
    e_valid = 1; e_bne = 1; e_beq = 0; e_PCp1 = 30'h25; e_Imm = 16'h0004;
    e_zero = ~taken; e_pred = taken;
  endtask

  task automatic probe(input logic [29:0] pcp1);
    d_valid = 1; d_br = 1; d_J = 0; d_PCp1 = pcp1; d_Imm = '0;
  endtask

  initial begin
    rst = 1; stall = 0; clr();
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_hold", 30'h0, 0, 0, 0, 16'd0, 4'b1111);
    rst = 0;
    cyc("pc0", 30'h0, 0, 0, 0, 16'd0, 4'b1111);
    cyc("pc1", 30'h1, 0, 0, 0, 16'd0, 4'b1000);
    cyc("pc2", 30'h2, 0, 0, 0, 16'd0, 4'b1000);
    cyc("pc3", 30'h3, 0, 0, 0, 16'd0, 4'b1000);
    stall = 1;
    cyc("pc4", 30'h4, 0, 0, 0, 16'd0, 4'b1000);
    cyc("stall1", 30'h4, 0, 0, 0, 16'd0, 4'b1000);
    stall = 0;
    cyc("stall2", 30'h4, 0, 0, 0, 16'd0, 4'b1000);

    // Decode jump
    d_valid = 1; d_J = 1; d_PCp1 = 30'h101; d_Imm = 26'h200;
    cyc("dj_flush", 30'h5, 1, 0, 0, 16'd0, 4'b1110);
    clr();
    cyc("dj_target", 30'h200, 0, 0, 0, 16'd0, 4'b1100);

    // BEQ decoded with weak not-taken, then mispredicted at execute
    d_valid = 1; d_br = 1; d_PCp1 = 30'h10; d_Imm = 26'h000FFFC;
    cyc("beq_dec_nt", 30'h201, 0, 0, 0, 16'd0, 4'b1110);
    clr();
    e_valid = 1; e_beq = 1; e_PCp1 = 30'h10; e_Imm = 16'hFFFC; e_zero = 1; e_pred = 0;
    cyc("beq_mis_flush", 30'h202, 1, 1, 0, 16'd0, 4'b1111);
    clr();
    cyc("beq_mis_tgt", 30'h0C, 0, 0, 0, 16'd1, 4'b1101);
    d_valid = 1; d_br = 1; d_PCp1 = 30'h10; d_Imm = 26'h000FFFC;
    cyc("beq_redec", 30'h0D, 1, 0, 1, 16'd1, 4'b1111);
    clr();
    cyc("beq_redec_tgt", 30'h0C, 0, 0, 0, 16'd1, 4'b1101);

    // Counter saturation at index 5; stall keeps PC and suppresses decode redirect
    stall = 1;
    exe_bne(1); probe(30'h25); cyc("sat_t1", 30'h0D, 0, 0, 0, 16'd1, 4'b1111);
    exe_bne(1); probe(30'h25); cyc("sat_t2", 30'h0D, 0, 0, 1, 16'd1, 4'b1111);
    exe_bne(1); probe(30'h25); cyc("sat_t3", 30'h0D, 0, 0, 1, 16'd1, 4'b1111);
    exe_bne(1); probe(30'h25); cyc("sat_t4", 30'h0D, 0, 0, 1, 16'd1, 4'b1111);
    exe_bne(0); probe(30'h25); cyc("sat_n1", 30'h0D, 0, 0, 1, 16'd1, 4'b1111);
    clr(); probe(30'h25);      cyc("sat_10", 30'h0D, 0, 0, 1, 16'd1, 4'b1111);
    exe_bne(0); probe(30'h25); cyc("sat_n2", 30'h0D, 0, 0, 1, 16'd1, 4'b1111);
    exe_bne(0); probe(30'h25); cyc("sat_n3", 30'h0D, 0, 0, 0, 16'd1, 4'b1111);
    exe_bne(0); probe(30'h25); cyc("sat_n4", 30'h0D, 0, 0, 0, 16'd1, 4'b1111);
    exe_bne(0); probe(30'h25); cyc("sat_n5", 30'h0D, 0, 0, 0, 16'd1, 4'b1111);
    clr(); probe(30'h25);      cyc("sat_00", 30'h0D, 0, 0, 0, 16'd1, 4'b1111);
    clr(); exe_bne(1);         cyc("sat_up", 30'h0D, 0, 0, 0, 16'd1, 4'b1111);
    clr(); probe(30'h25);      cyc("sat_01", 30'h0D, 0, 0, 0, 16'd1, 4'b1111);
    clr(); exe_bne(0);         cyc("sat_back00", 30'h0D, 0, 0, 0, 16'd1, 4'b1101);

    // JR under stall with a decode jump present: execute wins, no mispredict count
    clr();
    e_valid = 1; e_Jr = 1; e_adr_JR = 32'h0000_0403;
    d_valid = 1; d_J = 1; d_PCp1 = 30'h101; d_Imm = 26'h200;
    cyc("jr_flush", 30'h0D, 1, 1, 0, 16'd1, 4'b1101);
    clr(); stall = 0;
    cyc("jr_target", 30'h100, 0, 0, 0, 16'd1, 4'b1101);

    // Asynchronous reset pulse between edges during a redirect
    e_valid = 1; e_beq = 1; e_PCp1 = 30'h10; e_Imm = 16'hFFFC; e_zero = 1; e_pred = 0;
    expect_now("pre_rst_redir", 30'h101, 1, 1, 0, 16'd1, 4'b1101);
    #6;
    rst = 1; clr(); stall = 1;
    #2;
    rst = 0;
    @(posedge clk);
    #1;
    cyc("async_rst", 30'h0, 0, 0, 0, 16'd0, 4'b1101);
    exe_bne(1);
    cyc("rst_train5", 30'h0, 0, 0, 0, 16'd0, 4'b1101);
    clr(); probe(30'h25);
    cyc("rst_bht5", 30'h0, 0, 0, 1, 16'd0, 4'b1111);
    clr(); probe(30'h10);
    cyc("rst_bht0", 30'h0, 0, 0, 0, 16'd0, 4'b1111);
    clr(); stall = 0;

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      n_err += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/next_pc_bp.md
Name: next_pc_bp

Overview:
Parametrised next-PC unit for the pipelined MIPS32 core. It adds state to the combinational branch/jump selector:
- a PC register;
- a direct-mapped branch history table (BHT) of 2-bit saturating counters;
- decode-stage jump/branch prediction;
- execute-stage resolution with mispredict recovery and a mispredict counter.

It sits between fetch (drives the instruction memory address), decode (prediction) and execute (resolution).

Parameters:
PC_W, 30, word-address width of PC (byte address bits [PC_W+1:2]); must be >= 26
BHT_IDX, 4, log2 of BHT entries (16 entries default); must be < PC_W
RESET_PC, 0, word address loaded on reset
CNT_W, 16, mispredict counter width

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_stall  in  1  hold fetch PC (hazard stall)
o_PC  out  PC_W  current fetch word address (registered)
i_d_valid  in  1  decode slot holds a valid instruction
i_d_PCp1  in  PC_W  decode instruction word address + 1
i_d_Imm  in  26  decode instruction immediate/jump index
i_d_J  in  1  decode instruction is J/JAL
i_d_br  in  1  decode instruction is BEQ/BNE
o_d_pred_taken  out  1  prediction for decode branch (combinational)
i_e_valid  in  1  execute slot holds a valid instruction
i_e_PCp1  in  PC_W  execute instruction word address + 1
i_e_Imm  in  16  execute branch offset
i_e_beq  in  1  execute instruction is BEQ
i_e_bne  in  1  execute instruction is BNE
i_e_Jr  in  1  execute instruction is JR
i_e_zero  in  1  ALU zero flag
i_e_pred_taken  in  1  prediction carried from decode
i_e_adr_JR  in  32  JR register byte address
o_flush_fd  out  1  kill instruction in fetch/decode register (combinational)
o_flush_de  out  1  kill instruction in decode/execute register (combinational)
o_mispredicts  out  CNT_W  count of execute redirects caused by branch mispredict

Behaviour:
Reset (asynchronous, any time, including mid-redirect):
- o_PC = RESET_PC.
- All BHT entries = 2'b01 (weakly not-taken).
- o_mispredicts = 0.
- Combinational outputs follow inputs and reset state.

Arithmetic:
- Branch offsets are sign-extended from 16 bits to PC_W.
- Decode target = i_d_PCp1 + sext(i_d_Imm[15:0]); execute target = i_e_PCp1 + sext(i_e_Imm).
- Additions wrap modulo 2^PC_W.
- Jump target = {i_d_PCp1[PC_W-1:26], i_d_Imm}.
- JR target = i_e_adr_JR[PC_W+1:2] (bits [1:0] ignored).

BHT:
- Index = low BHT_IDX bits of PCp1.
- o_d_pred_taken = i_d_valid & i_d_br & counter[1].

Execute resolution:
- e_taken = (i_e_beq & i_e_zero) | (i_e_bne & ~i_e_zero).
- e_br = i_e_valid & (i_e_beq | i_e_bne).
- e_redirect = (e_br & (e_taken != i_e_pred_taken)) | (i_e_valid & i_e_Jr).
- Redirect target: JR target if Jr; else execute target if e_taken; else i_e_PCp1.
- On e_br, the indexed counter increments (taken, saturating at 11) or decrements (not taken, saturating at 00), independent of i_stall.

Decode redirect:
- d_redirect = ~i_stall & i_d_valid & (i_d_J | o_d_pred_taken).
- Target is the jump target if J, else the decode target.

Next-PC priority, evaluated each clock edge:
1. e_redirect: o_PC <= execute target. Overrides stall. Decode redirect is ignored.
2. d_redirect: o_PC <= decode target.
3. i_stall: o_PC holds.
4. Otherwise: o_PC <= o_PC + 1 (wraps).

Flush outputs:
- o_flush_fd = e_redirect | d_redirect.
- o_flush_de = e_redirect.

Mispredict counter:
- o_mispredicts increments on e_redirect caused by a branch mispredict (not JR).
- It saturates at all-ones.

Simultaneous events:
- BHT read and update to the same index in one cycle: the read returns the old value and the update is written at the edge.
- Decode J while execute mispredicts: execute wins.
- Redirect latency: the new PC appears on o_PC one cycle after the redirect condition.

Test Plan:
- Reset release, no control inputs, stall low for 4 cycles -> o_PC = 0,1,2,3,4. Stall high 2 cycles -> o_PC holds.
- Decode J with i_d_PCp1=0x0000101, Imm=0x0000200 (PC_W=30) -> next o_PC = {4'h0, 26'h0000200}, o_flush_fd=1, o_flush_de=0.
- BEQ at PCp1=0x10, Imm=0xFFFC, predicted not-taken, zero=1 at execute -> o_PC = 0x0C next cycle, both flushes = 1, o_mispredicts = 1, BHT[0] 01->10. Same branch redecoded -> o_d_pred_taken=1, o_PC = 0x0C after decode.
- Counter saturation: resolve a BNE taken 4 times -> counter 11. One not-taken -> 10, prediction still taken. Resolve not-taken to 00 and beyond -> stays 00.
- JR with adr_JR=0x00000403 while i_stall=1 and decode J valid -> o_PC = 0x100, o_flush_de=1, o_mispredicts unchanged.
- Assert i_rst asynchronously mid-cycle during a redirect -> o_PC = RESET_PC immediately, counter 0, all BHT entries read 01.
